riscv_muldiv: RTL and testbench
===============================

Name: riscv_muldiv

Overview:
Iterative RV32M/RV64M multiply/divide execution unit, parametrised in datapath width, attached beside the existing ALU in the core's execute stage. It accepts one operation per start pulse and computes the result over multiple cycles, one bit per cycle. It signals completion with a one-cycle done pulse so the control unit can stall the PC and register writeback until the result is ready. Divide-by-zero and signed-overflow cases follow the RISC-V M-extension rules exactly.

Parameters:
BITNESS, 32, operand/result width (32 or 64).
FAST_SPECIAL, 1, when 1 the divide-by-zero and signed-overflow cases bypass the CALC state.
CNT_WIDTH, $clog2(BITNESS)+1, iteration counter width (derived; not overridden).

Ports:
clk_i  input  1  clock, rising edge.
rst_i  input  1  reset, asynchronous, active-high.
start_i  input  1  launch operation; sampled only in IDLE.
flush_i  input  1  synchronous abort (pipeline flush); returns to IDLE, no done.
funct3_i  input  3  M-ext funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
op_a_i  input  BITNESS  rs1 value.
op_b_i  input  BITNESS  rs2 value.
busy_o  output  1  high whenever state != IDLE.
done_o  output  1  one-cycle completion pulse; result_o valid in the same cycle.
result_o  output  BITNESS  result, held stable until the next accepted start.

Behaviour:
- Reset (async, rst_i=1): state=IDLE; busy_o=0, done_o=0, result_o=0; internal accumulators and counter are cleared.
- States: IDLE, PREP, CALC, DONE.
- IDLE: start_i=1 and flush_i=0 at a clock edge → latch funct3_i and operands → PREP. start_i in any other state is ignored. No queueing.
- PREP (1 cycle):
  - Compute operand absolute values for signed ops (MULH: both signed; MULHSU: a signed, b unsigned; DIV/REM: both signed).
  - Record the result sign and load the counter with BITNESS.
  - Detect special cases:
    - b==0 on a divide/remainder.
    - a==most-negative and b==all-ones on DIV/REM.
  - FAST_SPECIAL=1 and a special case detected → DONE. Otherwise → CALC.
- CALC (exactly BITNESS cycles):
  - Multiply: shift-add, 2*BITNESS product register.
  - Divide: restoring shift-subtract, remainder plus quotient registers.
  - Counter decrements each cycle; count 1 → DONE.
- DONE (1 cycle): done_o=1, busy_o=1, result_o updated; then → IDLE.
  - MUL returns the low half of the product.
  - MULH/MULHSU/MULHU return the high half, negated first when the result sign is negative.
  - DIV/DIVU return the quotient; REM/REMU return the remainder. Quotient sign = sign a XOR sign b; remainder takes the sign of the dividend.
- Latency from the edge that samples start:
  - Normal ops: done_o high in the cycle after edge BITNESS+1.
  - Fast special cases: done_o high in the cycle after edge 1.
  - A new start is accepted no earlier than the edge that returns the unit to IDLE.
- Special results (identical whether fast path or CALC is used):
  - Divide by zero: DIV/DIVU → all ones; REM/REMU → op_a.
  - Signed overflow (DIV): most-negative; REM → 0.
- flush_i=1 in any state at an edge → IDLE, done_o not asserted, result_o unchanged. flush has priority over start.
- Reset mid-operation: immediate return to IDLE with all outputs 0; no partial result is exposed.

Decomposition:
- riscv_pkg: funct3 localparams for M-ext ops (MULDIV_MUL ... MULDIV_REMU) and the state enum typedef muldiv_state_t. These are shared with controlUnit decoding (op 0110011, funct7=0000001).
- Single module; the datapath is small enough that no sub-module is needed.

Test Plan:
- MUL, a=7, b=0xFFFFFFFD (-3), start pulse at edge 0 → result_o=0xFFFFFFEB; done_o high only in the cycle after edge 33; busy_o=1 for edges 1..33.
- High-half multiplies:
  - MULH 0x80000000*0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF*0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF*0xFFFFFFFF → 0xFFFFFFFF.
- Divides:
  - DIV -7/2 (0xFFFFFFF9/2) → 0xFFFFFFFD; REM → 0xFFFFFFFF.
  - DIVU 100/7 → 0x0000000E; REMU → 0x00000002.
- Divide by zero, a=5, b=0:
  - DIV and DIVU → 0xFFFFFFFF; REM and REMU → 0x00000005.
  - FAST_SPECIAL=1: done_o after edge 1. FAST_SPECIAL=0: same values, done_o after edge 33.
- Overflow: DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM → 0x00000000.
- Aborts:
  - flush_i pulsed at CALC edge 10 → IDLE next cycle, no done_o, result_o keeps its prior value.
  - rst_i asserted mid-CALC between edges → busy_o, done_o and result_o become 0 immediately.
  - start_i asserted while busy → ignored; the running result is unaffected.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32M/RV64M definitions: funct3 encodings for the M-extension
// (opcode 0110011, funct7 0000001) and the mul/div sequencer state type.
package riscv_pkg;

    localparam logic [2:0] MULDIV_MUL    = 3'b000;
    localparam logic [2:0] MULDIV_MULH   = 3'b001;
    localparam logic [2:0] MULDIV_MULHSU = 3'b010;
    localparam logic [2:0] MULDIV_MULHU  = 3'b011;
    localparam logic [2:0] MULDIV_DIV    = 3'b100;
    localparam logic [2:0] MULDIV_DIVU   = 3'b101;
    localparam logic [2:0] MULDIV_REM    = 3'b110;
    localparam logic [2:0] MULDIV_REMU   = 3'b111;

    typedef enum logic [1:0] {
        MD_IDLE,
        MD_PREP,
        MD_CALC,
        MD_DONE
    } muldiv_state_t;

endpackage

// File: rtl/riscv_muldiv.sv
// Iterative M-extension unit: one bit per cycle shift-add multiply and
// restoring divide, with RISC-V divide-by-zero / overflow results.
// Ports: clk_i, rst_i (async, active-high), start_i, flush_i, funct3_i,
//        op_a_i, op_b_i -> busy_o, done_o (1-cycle pulse), result_o.
module riscv_muldiv
    import riscv_pkg::*;
#(
    parameter int BITNESS      = 32,
    parameter bit FAST_SPECIAL = 1'b1,
    parameter int CNT_WIDTH    = $clog2(BITNESS) + 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic               flush_i,
    input  logic [2:0]         funct3_i,
    input  logic [BITNESS-1:0] op_a_i,
    input  logic [BITNESS-1:0] op_b_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [BITNESS-1:0] result_o
);

    localparam int W = BITNESS;

    muldiv_state_t        state;
    logic [2:0]           op;
    // a/b hold the raw operands in PREP and their magnitudes in CALC
    logic [W-1:0]         a;
    logic [W-1:0]         b;
    logic [2*W-1:0]       prod;
    logic [W-1:0]         rem;
    logic [W-1:0]         quo;
    logic [CNT_WIDTH-1:0] cnt;
    logic                 neg;
    logic                 done;
    logic [W-1:0]         result;

    logic           is_div, is_rem, a_signed, b_signed;
    logic           sa, sb, b_zero, ovf, special;
    logic [W-1:0]   mag_a, mag_b, special_res;
    logic [W:0]     psum, shifted, diff;
    logic [2*W-1:0] prod_nx, prod_fin;
    logic [W-1:0]   rem_nx, quo_nx, final_res;

    assign is_div   = op[2];
    assign is_rem   = op[2] & op[1];
    assign a_signed = (op == MULDIV_MULH) | (op == MULDIV_MULHSU)
                    | (op == MULDIV_DIV)  | (op == MULDIV_REM);
    assign b_signed = (op == MULDIV_MULH) | (op == MULDIV_DIV)
                    | (op == MULDIV_REM);

    assign sa    = a_signed & a[W-1];
    assign sb    = b_signed & b[W-1];
    assign mag_a = sa ? -a : a;
    assign mag_b = sb ? -b : b;

    assign b_zero  = is_div & (b == '0);
    assign ovf     = is_div & ~op[0]
                   & (a == {1'b1, {(W-1){1'b0}}}) & (b == '1);
    assign special = b_zero | ovf;

    always_comb begin
        special_res = '0;
        if (b_zero)
            special_res = is_rem ? a : '1;
        else if (!is_rem)
            special_res = a;
    end

    // Multiply: add |a| into the upper half when the multiplier LSB is set,
    // then shift the whole product right by one.
    assign psum     = {1'b0, prod[2*W-1:W]} + (prod[0] ? {1'b0, a} : '0);
    assign prod_nx  = {psum, prod[W-1:1]};
    assign prod_fin = neg ? -prod_nx : prod_nx;

    // Divide: restoring step, quotient bit is 1 when the trial subtract
    // does not borrow.
    assign shifted = {rem, quo[W-1]};
    assign diff    = shifted - {1'b0, b};
    assign rem_nx  = diff[W] ? shifted[W-1:0] : diff[W-1:0];
    assign quo_nx  = {quo[W-2:0], ~diff[W]};

    always_comb begin
        final_res = prod_fin[W-1:0];
        case (op)
            MULDIV_MUL:    final_res = prod_fin[W-1:0];
            MULDIV_MULH,
            MULDIV_MULHSU,
            MULDIV_MULHU:  final_res = prod_fin[2*W-1:W];
            MULDIV_DIV,
            MULDIV_DIVU:   final_res = neg ? -quo_nx : quo_nx;
            default:       final_res = neg ? -rem_nx : rem_nx;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state  <= MD_IDLE;
            op     <= '0;
            a      <= '0;
            b      <= '0;
            prod   <= '0;
            rem    <= '0;
            quo    <= '0;
            cnt    <= '0;
            neg    <= 1'b0;
            done   <= 1'b0;
            result <= '0;
        end else if (flush_i) begin
            state <= MD_IDLE;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                MD_IDLE: begin
                    if (start_i) begin
                        op    <= funct3_i;
                        a     <= op_a_i;
                        b     <= op_b_i;
                        state <= MD_PREP;
                    end
                end
                MD_PREP: begin
                    a    <= mag_a;
                    b    <= mag_b;
                    prod <= {{W{1'b0}}, mag_b};
                    rem  <= '0;
                    quo  <= mag_a;
                    cnt  <= CNT_WIDTH'(W);
                    // x/0 must yield all ones, so never negate that quotient
                    if (!is_div)
                        neg <= sa ^ sb;
                    else if (is_rem)
                        neg <= sa;
                    else
                        neg <= (sa ^ sb) & ~b_zero;
                    if (FAST_SPECIAL && special) begin
                        result <= special_res;
                        done   <= 1'b1;
                        state  <= MD_DONE;
                    end else begin
                        state <= MD_CALC;
                    end
                end
                MD_CALC: begin
                    prod <= prod_nx;
                    rem  <= rem_nx;
                    quo  <= quo_nx;
                    cnt  <= cnt - 1'b1;
                    if (cnt == CNT_WIDTH'(1)) begin
                        result <= final_res;
                        done   <= 1'b1;
                        state  <= MD_DONE;
                    end
                end
                default: state <= MD_IDLE;
            endcase
        end
    end

    assign busy_o   = (state != MD_IDLE);
    assign done_o   = done;
    assign result_o = result;

endmodule

// File: tb/tb_riscv_muldiv.sv
// Scoreboard bench for riscv_muldiv: fast- and slow-special instances run
// the same directed vectors; monitors check result and done timing.
module tb_riscv_muldiv;
    import riscv_pkg::*;

    typedef struct {
        logic [31:0] res;
        int          edge_n;
        string       name;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic        busy_f, done_f, busy_s, done_s;
    logic [31:0] res_f, res_s;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;
    exp_t q_f[$];
    exp_t q_s[$];

    riscv_muldiv #(.BITNESS(32), .FAST_SPECIAL(1'b1)) dut_fast (
        .clk_i(clk), .rst_i(rst), .start_i(start), .flush_i(flush),
        .funct3_i(funct3), .op_a_i(op_a), .op_b_i(op_b),
        .busy_o(busy_f), .done_o(done_f), .result_o(res_f)
    );

    riscv_muldiv #(.BITNESS(32), .FAST_SPECIAL(1'b0)) dut_slow (
        .clk_i(clk), .rst_i(rst), .start_i(start), .flush_i(flush),
        .funct3_i(funct3), .op_a_i(op_a), .op_b_i(op_b),
        .busy_o(busy_s), .done_o(done_s), .result_o(res_s)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] expv);
        n_total++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, expv);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (done_f) begin
            if (q_f.size() == 0) begin
                n_total++;
                $display("FAIL fast_unexpected_done: got done=1 result %h expected done=0", res_f);
            end else begin
                e = q_f.pop_front();
                chk({"fast_", e.name}, res_f, e.res);
                chk({"fast_", e.name, "_edge"}, 32'(cyc), 32'(e.edge_n));
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (done_s) begin
            if (q_s.size() == 0) begin
                n_total++;
                $display("FAIL slow_unexpected_done: got done=1 result %h expected done=0", res_s);
            end else begin
                e = q_s.pop_front();
                chk({"slow_", e.name}, res_s, e.res);
                chk({"slow_", e.name, "_edge"}, 32'(cyc), 32'(e.edge_n));
            end
        end
    end

    // Drive one op; e0 returns the edge number that samples start.
    task automatic launch(input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] expv,
                          input bit spec, input bit push,
                          input string nm, output int e0);
        exp_t e;
        @(negedge clk);
        funct3 = f;
        op_a   = a;
        op_b   = b;
        start  = 1'b1;
        e0     = cyc + 1;
        if (push) begin
            e.res    = expv;
            e.name   = nm;
            e.edge_n = e0 + (spec ? 1 : 33);
            q_f.push_back(e);
            e.edge_n = e0 + 33;
            q_s.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy_f || busy_s) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            n_total++;
            $display("FAIL idle_timeout: got busy %b/%b expected 0/0", busy_f, busy_s);
        end
        @(negedge clk);
    endtask

    task automatic run(input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] expv,
                       input bit spec, input string nm);
        int e0;
        launch(f, a, b, expv, spec, 1'b1, nm, e0);
        wait_idle();
    endtask

    initial begin
        int  e0;
        bit  ok;
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0;
        bit ok;
        repeat (2) @(negedge clk);
        chk("rst_busy", {31'b0, busy_f}, 32'h0);
        chk("rst_done", {31'b0, done_f}, 32'h0);
        chk("rst_result", res_f, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_busy", {31'b0, busy_s}, 32'h0);

        // MUL with busy window check
        launch(MULDIV_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, 1'b1,
               "mul", e0);
        ok = 1'b1;
        while (cyc <= e0 + 33) begin
            ok = ok & busy_f & busy_s;
            @(negedge clk);
        end
        chk("mul_busy_window", {31'b0, ok}, 32'h1);
        chk("mul_busy_clear", {30'b0, busy_f, busy_s}, 32'h0);
        wait_idle();

        run(MULDIV_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 0, "mulh");
        run(MULDIV_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0, "mulhu");
        run(MULDIV_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "mulhsu");
        run(MULDIV_MULHU,  32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 0, "mulhu_2p32");
        run(MULDIV_MUL,    32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 0, "mul_2p32");
        run(MULDIV_DIV,    32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 0, "div_neg");
        run(MULDIV_REM,    32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 0, "rem_neg");
        run(MULDIV_DIV,    32'd5, 32'd0, 32'hFFFF_FFFF, 1, "div_z");
        run(MULDIV_DIVU,   32'd5, 32'd0, 32'hFFFF_FFFF, 1, "divu_z");
        run(MULDIV_REM,    32'd5, 32'd0, 32'h0000_0005, 1, "rem_z");
        run(MULDIV_REMU,   32'd5, 32'd0, 32'h0000_0005, 1, "remu_z");
        run(MULDIV_DIV,    32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 1, "div_negz");
        run(MULDIV_REM,    32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 1, "rem_negz");
        run(MULDIV_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, "div_ovf");
        run(MULDIV_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1, "rem_ovf");
        run(MULDIV_DIVU,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 0, "divu_big");
        run(MULDIV_REMU,   32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0, "remu_big");
        run(MULDIV_DIVU,   32'd100, 32'd7, 32'h0000_000E, 0, "divu");
        run(MULDIV_REMU,   32'd100, 32'd7, 32'h0000_0002, 0, "remu");

        // flush at CALC edge 10: no done, result keeps 2
        launch(MULDIV_MUL, 32'd3, 32'd5, 32'd15, 1'b0, 1'b0, "flushed", e0);
        while (cyc < e0 + 10) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_busy", {30'b0, busy_f, busy_s}, 32'h0);
        chk("flush_result_fast", res_f, 32'h0000_0002);
        chk("flush_result_slow", res_s, 32'h0000_0002);
        repeat (40) @(negedge clk);

        // start while busy is ignored
        launch(MULDIV_DIVU, 32'd100, 32'd7, 32'h0000_000E, 1'b0, 1'b1,
               "busy_start", e0);
        while (cyc < e0 + 5) @(negedge clk);
        funct3 = MULDIV_MUL;
        op_a   = 32'd2;
        op_b   = 32'd3;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle();
        repeat (5) @(negedge clk);

        // async reset mid-CALC
        launch(MULDIV_MUL, 32'd7, 32'd9, 32'd63, 1'b0, 1'b0, "reset", e0);
        while (cyc < e0 + 15) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_busy", {30'b0, busy_f, busy_s}, 32'h0);
        chk("mid_rst_done", {30'b0, done_f, done_s}, 32'h0);
        chk("mid_rst_result_fast", res_f, 32'h0);
        chk("mid_rst_result_slow", res_s, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        run(MULDIV_MUL, 32'd6, 32'd7, 32'd42, 0, "mul_after_rst");

        chk("fast_queue_empty", 32'(q_f.size()), 32'h0);
        chk("slow_queue_empty", 32'(q_s.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
